// File: rtl/uart_word_tx_if.sv
// Host-facing and RAM-facing signals of the word transmitter.
// master = host/RAM side, slave = transmitter side.
interface uart_word_tx_if;
   logic        tx_valid;
   logic [15:0] tx_data;
   logic        tx_ready;
   logic        dump_start;
   logic [7:0]  dump_len;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic        tx;
   logic        busy;
   logic        dump_done;

   modport master (
      output tx_valid, tx_data, dump_start, dump_len, mem_data,
      input  tx_ready, mem_addr, tx, busy, dump_done
   );

   modport slave (
      input  tx_valid, tx_data, dump_start, dump_len, mem_data,
      output tx_ready, mem_addr, tx, busy, dump_done
   );
endinterface

// File: rtl/uart_word_tx.sv
// 8N1 UART word transmitter: sends 16-bit words as two frames, low byte first.
// Words come from the host handshake or from a dump of a sync-read RAM.
// One bit lasts DELAY+1 clk cycles.
module uart_word_tx #(
   parameter int DELAY = 234
) (
   input  logic          clk,
   input  logic          reset,
   uart_word_tx_if.slave bus
);

   localparam logic [7:0] DLY = 8'(DELAY);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

   state_t      state;
   logic [7:0]  bit_cnt;
   logic [2:0]  bit_idx;
   logic [15:0] word;
   logic        byte_sel;
   logic        dumping;
   logic [7:0]  len;
   logic [7:0]  addr;
   logic        line;
   logic        rdy;
   logic        active;
   logic        done;

   logic [7:0]  cur_byte;
   logic [2:0]  nxt_idx;
   logic        bit_end;
   logic [7:0]  len_m1;

   // byte currently on the wire and end-of-bit strobe
   always_comb begin
      cur_byte = byte_sel ? word[15:8] : word[7:0];
      nxt_idx  = bit_idx + 3'd1;
      bit_end  = (bit_cnt == DLY);
      len_m1   = len - 8'd1;
   end

   // single FSM; every output is a register set on the transition into a state
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= 8'd0;
         bit_idx  <= 3'd0;
         word     <= 16'd0;
         byte_sel <= 1'b0;
         dumping  <= 1'b0;
         len      <= 8'd0;
         addr     <= 8'd0;
         line     <= 1'b1;
         rdy      <= 1'b1;
         active   <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               line    <= 1'b1;
               bit_cnt <= 8'd0;
               // dump request wins over a simultaneous host word
               if (bus.dump_start) begin
                  if (bus.dump_len == 8'd0) begin
                     done <= 1'b1;
                  end else begin
                     len      <= bus.dump_len;
                     addr     <= 8'd0;
                     dumping  <= 1'b1;
                     byte_sel <= 1'b0;
                     state    <= FETCH;
                     active   <= 1'b1;
                     rdy      <= 1'b0;
                  end
               end else if (bus.tx_valid) begin
                  word     <= bus.tx_data;
                  byte_sel <= 1'b0;
                  state    <= START;
                  line     <= 1'b0;
                  active   <= 1'b1;
                  rdy      <= 1'b0;
               end
            end
            FETCH: begin
               // address held for two cycles; RAM data is valid on the second edge
               if (bit_cnt == 8'd1) begin
                  word     <= bus.mem_data;
                  bit_cnt  <= 8'd0;
                  byte_sel <= 1'b0;
                  state    <= START;
                  line     <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_cnt <= 8'd0;
                  bit_idx <= 3'd0;
                  state   <= DATA;
                  line    <= cur_byte[0];
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= 8'd0;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     line  <= 1'b1;
                  end else begin
                     bit_idx <= nxt_idx;
                     line    <= cur_byte[nxt_idx];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  bit_cnt <= 8'd0;
                  if (!byte_sel) begin
                     // high byte follows with no idle gap
                     byte_sel <= 1'b1;
                     state    <= START;
                     line     <= 1'b0;
                  end else if (!dumping) begin
                     state  <= IDLE;
                     active <= 1'b0;
                     rdy    <= 1'b1;
                  end else if (addr < len_m1) begin
                     addr  <= addr + 8'd1;
                     state <= FETCH;
                  end else begin
                     dumping <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                     active  <= 1'b0;
                     rdy     <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx        = line;
   assign bus.tx_ready  = rdy;
   assign bus.busy      = active;
   assign bus.dump_done = done;
   assign bus.mem_addr  = addr;

endmodule
